// File: rtl/param_hash_pkg.sv
// param_hash_pkg
//   Shared declarations for the param_hash block:
//   - state_e : control FSM state encoding
//   - rotl    : width-generic left rotate (operates on the low w bits of x)
package param_hash_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Rotates the low w bits of x left by r; bits at and above w come back as 0.
  // The container is as wide as the widest supported digest.
  function automatic logic [127:0] rotl(input logic [127:0] x,
                                        input int unsigned w,
                                        input int unsigned r);
    logic [127:0] m;
    logic [127:0] xm;
    m  = (w >= 128) ? '1 : ((128'd1 << w) - 128'd1);
    xm = x & m;
    return ((xm << r) | (xm >> (w - r))) & m;
  endfunction

endpackage

// File: rtl/param_hash_bit_reverse.sv
// bit_reverse
//   Purely combinational bit-order reversal, out_o[i] = in_i[W-1-i].
//   Ports:
//     in_i  [W-1:0]  value to reverse
//     out_o [W-1:0]  reversed value
module bit_reverse #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_i,
  output logic [W-1:0] out_o
);

  always_comb begin
    for (int i = 0; i < W; i++) begin
      out_o[i] = in_i[W-1-i];
    end
  end

endmodule

// File: rtl/param_hash.sv
// param_hash
//   Iterated rotate/XOR hash over a byte stream. Each byte is folded into the
//   chaining state for ROUNDS cycles; at the end the byte count is mixed in and
//   the digest is presented on R_h, optionally bit-reversed.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     start        begin (or restart) a message
//     Byte         input beat, lane 0 = Byte[7:0] processed first
//     last_cnt     valid bytes in the final beat (0..NB)
//     End_of_File  marks the accepted beat as the last one
//     F_dr / F_rtr source valid / block ready handshake
//     rev_out      bit-reverse the digest (sampled when the digest is formed)
//     h_ack        consumer has taken the digest
//     H_ready, R_h digest valid flag and registered digest
//
//   state   | meaning
//   --------+-------------------------------------------------
//   S_IDLE  | no message in progress
//   S_WAIT  | ready for the next beat (F_rtr high)
//   S_ROUND | folding the current beat, one round per cycle
//   S_FINAL | one cycle: mix in length, register digest
//   S_DONE  | digest held on R_h until h_ack or start
module param_hash
  import param_hash_pkg::*;
#(
  parameter int              DW     = 32,
  parameter int              NB     = 1,
  parameter int              ROUNDS = 8,
  parameter int              ROT    = 5,
  parameter logic [DW-1:0]   IV     = DW'(32'h6A09E667)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [8*NB-1:0]          Byte,
  input  logic [$clog2(NB+1)-1:0]  last_cnt,
  input  logic                     End_of_File,
  input  logic                     F_dr,
  output logic                     F_rtr,
  input  logic                     rev_out,
  input  logic                     h_ack,
  output logic                     H_ready,
  output logic [DW-1:0]            R_h
);

  localparam int LCW = $clog2(NB+1);
  localparam int LW  = (NB > 1) ? $clog2(NB) : 1;

  state_e          state_q;
  logic [DW-1:0]   h_q;
  logic [DW-1:0]   len_q;
  logic [DW-1:0]   r_h_q;
  logic [8*NB-1:0] beat_q;
  logic [LCW-1:0]  nbytes_q;
  logic [LW-1:0]   lane_q;
  logic [3:0]      rnd_q;
  logic            last_q;
  logic            f_rtr_q;
  logic            h_ready_q;

  logic [7:0]      cur_byte;
  logic [DW-1:0]   h_d;
  logic [DW-1:0]   digest_d;
  logic [DW-1:0]   digest_rev;
  logic [LCW-1:0]  beat_bytes;
  logic            byte_done;
  logic            beat_done;

  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < NB; i++) begin
      if (LW'(i) == lane_q) cur_byte = beat_q[i*8 +: 8];
    end
  end

  assign h_d        = DW'(rotl(128'(h_q ^ {(DW/8){cur_byte}}), DW, ROT));
  assign digest_d   = h_q ^ len_q;
  assign beat_bytes = End_of_File ? last_cnt : LCW'(NB);
  assign byte_done  = (rnd_q == 4'(ROUNDS-1));
  assign beat_done  = byte_done && ((LCW'(lane_q) + LCW'(1)) == nbytes_q);

  bit_reverse #(.W(DW)) u_bit_reverse (
    .in_i  (digest_d),
    .out_o (digest_rev)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      h_q       <= '0;
      len_q     <= '0;
      r_h_q     <= '0;
      beat_q    <= '0;
      nbytes_q  <= '0;
      lane_q    <= '0;
      rnd_q     <= '0;
      last_q    <= 1'b0;
      f_rtr_q   <= 1'b0;
      h_ready_q <= 1'b0;
    end else if (start) begin
      // Same action from every state: a fresh message, anything in flight is dropped.
      state_q   <= S_WAIT;
      h_q       <= IV;
      len_q     <= '0;
      lane_q    <= '0;
      rnd_q     <= '0;
      f_rtr_q   <= 1'b1;
      h_ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (F_dr && f_rtr_q) begin
            beat_q   <= Byte;
            last_q   <= End_of_File;
            nbytes_q <= beat_bytes;
            lane_q   <= '0;
            rnd_q    <= '0;
            f_rtr_q  <= 1'b0;
            state_q  <= (beat_bytes == '0) ? S_FINAL : S_ROUND;
          end
        end
        S_ROUND: begin
          h_q <= h_d;
          if (byte_done) begin
            rnd_q <= '0;
            len_q <= len_q + DW'(1);
            if (beat_done) begin
              lane_q  <= '0;
              f_rtr_q <= !last_q;
              state_q <= last_q ? S_FINAL : S_WAIT;
            end else begin
              lane_q <= lane_q + LW'(1);
            end
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        S_FINAL: begin
          r_h_q     <= rev_out ? digest_rev : digest_d;
          h_ready_q <= 1'b1;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          if (h_ack) begin
            h_ready_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_IDLE: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign F_rtr   = f_rtr_q;
  assign H_ready = h_ready_q;
  assign R_h     = r_h_q;

endmodule

// File: tb/tb_param_hash.sv
// tb_param_hash
//   Directed bench. Three instances:
//     u_a : IV=0, ROUNDS=1, ROT=1, NB=1   (hand-computed digests)
//     u_b : IV=0xF, NB=1, shares u_a's inputs (zero-byte finish)
//     u_c : NB=4, ROUNDS=8, ROT=5, default IV (compared to a small model)
module tb_param_hash;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_start, a_eof, a_fdr, a_rev, a_hack;
  logic [7:0]  a_byte;
  logic [0:0]  a_lc;
  logic        a_rtr, a_hrdy, b_rtr, b_hrdy;
  logic [31:0] a_rh, b_rh;

  logic        c_start, c_eof, c_fdr, c_rev, c_hack;
  logic [31:0] c_byte;
  logic [2:0]  c_lc;
  logic        c_rtr, c_hrdy;
  logic [31:0] c_rh;

  int n_vec = 0;
  int n_err = 0;

  param_hash #(.DW(32), .NB(1), .ROUNDS(1), .ROT(1), .IV(32'h0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .Byte(a_byte), .last_cnt(a_lc),
    .End_of_File(a_eof), .F_dr(a_fdr), .F_rtr(a_rtr), .rev_out(a_rev),
    .h_ack(a_hack), .H_ready(a_hrdy), .R_h(a_rh));

  param_hash #(.DW(32), .NB(1), .ROUNDS(8), .ROT(5), .IV(32'h0000000F)) u_b (
    .clk(clk), .rst_n(rst_n), .start(a_start), .Byte(a_byte), .last_cnt(a_lc),
    .End_of_File(a_eof), .F_dr(a_fdr), .F_rtr(b_rtr), .rev_out(a_rev),
    .h_ack(a_hack), .H_ready(b_hrdy), .R_h(b_rh));

  param_hash #(.DW(32), .NB(4), .ROUNDS(8), .ROT(5)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .Byte(c_byte), .last_cnt(c_lc),
    .End_of_File(c_eof), .F_dr(c_fdr), .F_rtr(c_rtr), .rev_out(c_rev),
    .h_ack(c_hack), .H_ready(c_hrdy), .R_h(c_rh));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference fold of one byte for the u_c configuration (8 rounds, rotate by 5).
  function automatic logic [31:0] m_byte(input logic [31:0] h, input logic [7:0] b);
    logic [31:0] t;
    t = h;
    for (int r = 0; r < 8; r++) begin
      t = t ^ {4{b}};
      t = (t << 5) | (t >> 27);
    end
    return t;
  endfunction

  task automatic a_pulse_start();
    @(negedge clk); a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
  endtask

  task automatic a_beat(input logic [7:0] b, input logic eof, input logic lc);
    int n;
    n = 0;
    @(negedge clk);
    while (!a_rtr && n < 20) begin @(negedge clk); n++; end
    chk("a_rtr_wait", 32'(a_rtr), 32'd1);
    a_byte = b; a_eof = eof; a_lc = lc; a_fdr = 1'b1;
    @(posedge clk); #1 a_fdr = 1'b0; a_eof = 1'b0;
  endtask

  task automatic a_lat(output int lat);
    lat = 0;
    while (!a_hrdy && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic a_ack();
    @(negedge clk); a_hack = 1'b1;
    @(posedge clk); #1 a_hack = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    logic [31:0] mh;

    rst_n = 1'b0;
    a_start = 0; a_eof = 0; a_fdr = 0; a_rev = 0; a_hack = 0; a_byte = '0; a_lc = '0;
    c_start = 0; c_eof = 0; c_fdr = 0; c_rev = 0; c_hack = 0; c_byte = '0; c_lc = '0;
    #1;
    chk("rst_rh",    a_rh, 32'h0);
    chk("rst_hrdy",  32'(a_hrdy), 32'd0);
    chk("rst_rtr",   32'(a_rtr), 32'd0);
    #20;
    @(negedge clk) rst_n = 1'b1;

    // Zero-byte finish, natural order
    a_pulse_start();
    chk("start_rtr_a", 32'(a_rtr), 32'd1);
    chk("start_rtr_b", 32'(b_rtr), 32'd1);
    a_beat(8'h00, 1'b1, 1'b0);
    a_lat(lat);
    chk("zb_lat", 32'(lat), 32'd1);
    chk("zb_b_hrdy", 32'(b_hrdy), 32'd1);
    chk("zb_b_rh", b_rh, 32'h0000000F);
    chk("zb_a_rh", a_rh, 32'h0);
    a_ack();

    // Zero-byte finish, reversed
    a_rev = 1'b1;
    a_pulse_start();
    a_beat(8'h00, 1'b1, 1'b0);
    a_lat(lat);
    chk("zb_rev_b_rh", b_rh, 32'hF0000000);
    a_ack();

    // One byte, reversed
    a_pulse_start();
    a_beat(8'h01, 1'b1, 1'b1);
    a_lat(lat);
    chk("b1_rev_lat", 32'(lat), 32'd2);
    chk("b1_rev_rh", a_rh, 32'hC0404040);
    a_ack();

    // One byte, natural order; hold, then acknowledge
    a_rev = 1'b0;
    a_pulse_start();
    a_beat(8'h01, 1'b1, 1'b1);
    a_lat(lat);
    chk("b1_lat", 32'(lat), 32'd2);
    chk("b1_rh", a_rh, 32'h02020203);
    repeat (3) @(posedge clk);
    #1;
    chk("b1_hold_hrdy", 32'(a_hrdy), 32'd1);
    chk("b1_hold_rtr", 32'(a_rtr), 32'd0);
    a_ack();
    chk("ack_hrdy", 32'(a_hrdy), 32'd0);
    chk("ack_rh_kept", a_rh, 32'h02020203);

    // Abort during ROUND, then a clean message
    a_rev = 1'b1;
    a_pulse_start();
    a_beat(8'h55, 1'b1, 1'b1);
    @(negedge clk); a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    chk("abort_rtr", 32'(a_rtr), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_hrdy", 32'(a_hrdy), 32'd0);
    a_beat(8'h01, 1'b1, 1'b1);
    a_lat(lat);
    chk("abort_lat", 32'(lat), 32'd2);
    chk("abort_rh", a_rh, 32'hC0404040);
    // u_a stays in DONE through the u_c test below

    // NB=4: full non-last beat then 3-byte final beat
    @(negedge clk); c_start = 1'b1;
    @(posedge clk); #1 c_start = 1'b0;
    chk("c_rtr_start", 32'(c_rtr), 32'd1);
    @(negedge clk);
    c_byte = 32'h44332211; c_eof = 1'b0; c_lc = 3'd0; c_fdr = 1'b1;
    @(posedge clk); #1 c_fdr = 1'b0;
    n = 0;
    while (!c_rtr && n < 100) begin @(posedge clk); #1; n++; end
    chk("c_full_beat_busy", 32'(n), 32'd32);
    @(negedge clk);
    c_byte = 32'hDDCCBBAA; c_eof = 1'b1; c_lc = 3'd3; c_fdr = 1'b1;
    @(posedge clk); #1 c_fdr = 1'b0; c_eof = 1'b0;
    lat = 0;
    while (!c_hrdy && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("c_last_lat", 32'(lat), 32'd25);
    mh = 32'h6A09E667;
    mh = m_byte(mh, 8'h11); mh = m_byte(mh, 8'h22); mh = m_byte(mh, 8'h33);
    mh = m_byte(mh, 8'h44); mh = m_byte(mh, 8'hAA); mh = m_byte(mh, 8'hBB);
    mh = m_byte(mh, 8'hCC);
    chk("c_digest", c_rh, mh ^ 32'd7);

    // Asynchronous reset in the middle of u_c's ROUND
    @(negedge clk); c_start = 1'b1;
    @(posedge clk); #1 c_start = 1'b0;
    @(negedge clk);
    c_byte = 32'h01020304; c_eof = 1'b1; c_lc = 3'd4; c_fdr = 1'b1;
    @(posedge clk); #1 c_fdr = 1'b0; c_eof = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_c_rh", c_rh, 32'h0);
    chk("arst_c_rtr", 32'(c_rtr), 32'd0);
    chk("arst_a_rh", a_rh, 32'h0);
    chk("arst_a_hrdy", 32'(a_hrdy), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(c_rtr), 32'd0);

    // DONE: F_dr ignored, then start+h_ack together starts a new message
    a_rev = 1'b0;
    a_pulse_start();
    a_beat(8'h01, 1'b1, 1'b1);
    a_lat(lat);
    chk("re_rh", a_rh, 32'h02020203);
    @(negedge clk); a_fdr = 1'b1; a_eof = 1'b1; a_byte = 8'hFF; a_lc = 1'b1;
    @(posedge clk); #1 a_fdr = 1'b0; a_eof = 1'b0;
    chk("done_fdr_hrdy", 32'(a_hrdy), 32'd1);
    chk("done_fdr_rh", a_rh, 32'h02020203);
    @(negedge clk); a_start = 1'b1; a_hack = 1'b1;
    @(posedge clk); #1 a_start = 1'b0; a_hack = 1'b0;
    chk("sa_hrdy", 32'(a_hrdy), 32'd0);
    chk("sa_rtr", 32'(a_rtr), 32'd1);
    a_beat(8'h00, 1'b1, 1'b0);
    a_lat(lat);
    chk("sa_lat", 32'(lat), 32'd1);
    chk("sa_rh", a_rh, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
